// File: rtl/i2c_tx_pkg.sv
// Shared types and constants for the I2C-style frame transmitter.
// Optional parity bit enabled by defining I2C_TX_PARITY_BIT_EN.
package i2c_tx_pkg;

  localparam int SCAN_CODE_WIDTH = 8;

`ifdef I2C_TX_PARITY_BIT_EN
  localparam int FRAME_BITS = SCAN_CODE_WIDTH + 1;
`else
  localparam int FRAME_BITS = SCAN_CODE_WIDTH;
`endif

  localparam int BIT_IDX_W = $clog2(FRAME_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT_LOW,
    BIT_HIGH,
    STOP_LOW,
    STOP_HIGH,
    BUS_FREE
  } tx_state_e;

  // Odd parity: data ones plus parity bit always totals an odd count.
  function automatic logic odd_parity(input logic [SCAN_CODE_WIDTH-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/i2c_frame_transmitter_if.sv
// Request handshake and serial line bundle between a requester and the transmitter.
interface i2c_frame_transmitter_if;
  import i2c_tx_pkg::*;

  logic [SCAN_CODE_WIDTH-1:0] tx_data;
  logic                       tx_valid;
  logic                       tx_ready;
  logic                       tx_done;
  logic                       sda;
  logic                       scl;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  tx_done,
    input  sda,
    input  scl
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output tx_done,
    output sda,
    output scl
  );

endinterface

// File: rtl/i2c_frame_transmitter_half_period_timer.sv
// Free-running 0..HALF_PERIOD_CYCLES-1 counter; tc marks the last cycle of each phase.
module half_period_timer #(
  parameter int HALF_PERIOD_CYCLES = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tc
);

  localparam int CNT_W = (HALF_PERIOD_CYCLES > 1) ? $clog2(HALF_PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Wrapping on tc keeps every phase exactly HALF_PERIOD_CYCLES long.
  assign tc = (cnt == LAST) && !restart;

endmodule

// File: rtl/i2c_frame_transmitter.sv
// Serialises one scan code per handshake as start, MSB-first bits, stop, bus-free.
// Define I2C_TX_PARITY_BIT_EN to append an odd parity bit after the data bits.
module i2c_frame_transmitter
  import i2c_tx_pkg::*;
#(
  parameter int HALF_PERIOD_CYCLES = 250
) (
  input  logic                   fpga_clock,
  input  logic                   reset,
  i2c_frame_transmitter_if.slave bus
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(FRAME_BITS - 1);

  tx_state_e              state;
  tx_state_e              state_nx;
  logic [BIT_IDX_W-1:0]   bit_idx;
  logic [FRAME_BITS-1:0]  frame;
  logic                   tx_done_q;
  logic                   done_nx;
  logic                   accept;
  logic                   last_bit;
  logic                   tc;
  logic                   sda_c;
  logic                   scl_c;

  half_period_timer #(
    .HALF_PERIOD_CYCLES(HALF_PERIOD_CYCLES)
  ) u_timer (
    .clk     (fpga_clock),
    .rst     (reset),
    .restart (state == IDLE),
    .tc      (tc)
  );

  assign accept   = (state == IDLE) && bus.tx_valid;
  assign last_bit = (bit_idx == LAST_BIT);

  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    unique case (state)
      IDLE:      if (accept) state_nx = START;
      START:     if (tc) state_nx = BIT_LOW;
      BIT_LOW:   if (tc) state_nx = BIT_HIGH;
      BIT_HIGH:  if (tc) state_nx = last_bit ? STOP_LOW : BIT_LOW;
      STOP_LOW:  if (tc) state_nx = STOP_HIGH;
      STOP_HIGH: if (tc) state_nx = BUS_FREE;
      BUS_FREE: begin
        if (tc) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    sda_c = 1'b1;
    scl_c = 1'b1;
    unique case (state)
      IDLE:      begin sda_c = 1'b1; scl_c = 1'b1; end
      START:     begin sda_c = 1'b0; scl_c = 1'b1; end
      BIT_LOW:   begin sda_c = frame[FRAME_BITS-1]; scl_c = 1'b0; end
      BIT_HIGH:  begin sda_c = frame[FRAME_BITS-1]; scl_c = 1'b1; end
      STOP_LOW:  begin sda_c = 1'b0; scl_c = 1'b0; end
      STOP_HIGH: begin sda_c = 1'b0; scl_c = 1'b1; end
      BUS_FREE:  begin sda_c = 1'b1; scl_c = 1'b1; end
      default:   begin sda_c = 1'b1; scl_c = 1'b1; end
    endcase
  end

  always_ff @(posedge fpga_clock) begin
    if (reset) begin
      state     <= IDLE;
      tx_done_q <= 1'b0;
      bit_idx   <= '0;
    end else begin
      state     <= state_nx;
      tx_done_q <= done_nx;
      if (accept) begin
        bit_idx <= '0;
      end else if ((state == BIT_HIGH) && tc && !last_bit) begin
        bit_idx <= bit_idx + BIT_IDX_W'(1);
      end
    end
  end

  // Shift register holds the frame MSB-first; it only moves on BIT_HIGH -> BIT_LOW.
  always_ff @(posedge fpga_clock) begin
    if (accept) begin
`ifdef I2C_TX_PARITY_BIT_EN
      frame <= {bus.tx_data, odd_parity(bus.tx_data)};
`else
      frame <= bus.tx_data;
`endif
    end else if ((state == BIT_HIGH) && tc) begin
      frame <= {frame[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign bus.sda      = sda_c;
  assign bus.scl      = scl_c;
  assign bus.tx_ready = (state == IDLE);
  assign bus.tx_done  = tx_done_q;

endmodule

// File: tb/tb_i2c_frame_transmitter.sv
// Directed bench for i2c_frame_transmitter at four cycles per scl half-period.
module tb_i2c_frame_transmitter;

  localparam int T = 4;
`ifdef I2C_TX_PARITY_BIT_EN
  localparam int NRISE = 10;
  localparam int LAT   = 89;
  localparam logic [9:0] EXP_A5 = 10'h296;
  localparam logic [9:0] EXP_00 = 10'h002;
  localparam logic [9:0] EXP_01 = 10'h004;
  localparam logic [9:0] EXP_12 = 10'h04A;
  localparam logic [9:0] EXP_34 = 10'h0D0;
  localparam logic [9:0] EXP_3C = 10'h0F2;
`else
  localparam int NRISE = 9;
  localparam int LAT   = 81;
  localparam logic [9:0] EXP_A5 = 10'h14A;
  localparam logic [9:0] EXP_00 = 10'h000;
  localparam logic [9:0] EXP_01 = 10'h002;
  localparam logic [9:0] EXP_12 = 10'h024;
  localparam logic [9:0] EXP_34 = 10'h068;
  localparam logic [9:0] EXP_3C = 10'h078;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  i2c_frame_transmitter_if bus();

  i2c_frame_transmitter #(
    .HALF_PERIOD_CYCLES(T)
  ) dut (
    .fpga_clock (clk),
    .reset      (reset),
    .bus        (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drives one handshake from a negedge in IDLE and watches the line until tx_done.
  // cap collects sda at every scl rise (data bits, optional parity, then the stop rise).
  task automatic run_frame(input logic [7:0] d, input bit keep, input logic [7:0] nd,
                           input int pulse_at, output logic [9:0] cap, output int nr,
                           output int lat, output int viol, output int hi_edges);
    logic ps, pc;
    int   low_run;
    bit   done;
    cap = '0; nr = 0; lat = 0; viol = 0; hi_edges = 0; low_run = 0; done = 0;
    ps = bus.sda;
    pc = bus.scl;
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.tx_data  = nd;
        bus.tx_valid = keep;
      end
      if (!keep && pulse_at > 0 && lat == pulse_at) begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hFF;
      end
      if (!keep && pulse_at > 0 && lat == pulse_at + 1) begin
        bus.tx_valid = 1'b0;
        bus.tx_data  = nd;
      end
      if (bus.tx_done === 1'b1) done = 1;
      else if (bus.tx_ready !== 1'b0) viol++;
      if (pc && bus.scl && (bus.sda !== ps)) hi_edges++;
      if (!pc && bus.scl) begin
        if (bus.sda !== ps) viol++;
        if (low_run != T) viol++;
        cap = {cap[8:0], bus.sda};
        nr++;
      end
      low_run = bus.scl ? 0 : low_run + 1;
      ps = bus.sda;
      pc = bus.scl;
    end
    if (!done) lat = -1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] cap;
    int nr, lat, viol, hi, cnt;

    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_sda", bus.sda, 1);
    chk("rst_scl", bus.scl, 1);
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_done", bus.tx_done, 0);
    reset = 1'b0;
    @(negedge clk);

    run_frame(8'hA5, 0, 8'h5A, 0, cap, nr, lat, viol, hi);
    chk("a5_bits", cap, EXP_A5);
    chk("a5_rises", nr, NRISE);
    chk("a5_latency", lat, LAT);
    chk("a5_viol", viol, 0);
    chk("a5_start_stop", hi, 2);
    @(negedge clk);
    chk("a5_done_1cyc", bus.tx_done, 0);
    chk("a5_ready_after", bus.tx_ready, 1);

    run_frame(8'h00, 0, 8'hFF, 0, cap, nr, lat, viol, hi);
    chk("h00_bits", cap, EXP_00);
    chk("h00_latency", lat, LAT);
    @(negedge clk);
    run_frame(8'h01, 0, 8'hFE, 0, cap, nr, lat, viol, hi);
    chk("h01_bits", cap, EXP_01);
    chk("h01_viol", viol, 0);
    @(negedge clk);

    // Back-to-back: valid stays high, second handshake lands in the tx_done cycle.
    run_frame(8'h12, 1, 8'h34, 0, cap, nr, lat, viol, hi);
    chk("b2b1_bits", cap, EXP_12);
    chk("b2b1_latency", lat, LAT);
    chk("b2b1_ready_in_done", bus.tx_ready, 1);
    run_frame(8'h34, 0, 8'h00, 0, cap, nr, lat, viol, hi);
    chk("b2b2_bits", cap, EXP_34);
    chk("b2b2_latency", lat, LAT);
    chk("b2b2_start_stop", hi, 2);
    chk("b2b2_viol", viol, 0);
    @(negedge clk);
    chk("b2b2_done_1cyc", bus.tx_done, 0);

    // Request pulsed during the first BIT_HIGH must be ignored.
    run_frame(8'h3C, 0, 8'hC3, 10, cap, nr, lat, viol, hi);
    chk("ignore_bits", cap, EXP_3C);
    chk("ignore_latency", lat, LAT);
    @(negedge clk);
    chk("ignore_idle", bus.tx_ready, 1);

    // Reset during bit 3 low phase aborts the frame without a stop or done pulse.
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hA5;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (28) @(negedge clk);
    chk("abort_in_bit_low", bus.scl, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_sda", bus.sda, 1);
    chk("abort_scl", bus.scl, 1);
    chk("abort_ready", bus.tx_ready, 1);
    chk("abort_done", bus.tx_done, 0);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.tx_done !== 1'b0 || bus.sda !== 1'b1 || bus.scl !== 1'b1) cnt++;
    end
    chk("abort_quiet", cnt, 0);

    // Reset wins over a simultaneous handshake.
    reset = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hA5;
    @(negedge clk);
    chk("rst_vs_hs_ready", bus.tx_ready, 1);
    chk("rst_vs_hs_sda", bus.sda, 1);
    reset = 1'b0;
    bus.tx_valid = 1'b0;
    @(negedge clk);
    chk("rst_vs_hs_idle", bus.sda, 1);

    run_frame(8'hA5, 0, 8'h00, 0, cap, nr, lat, viol, hi);
    chk("recover_bits", cap, EXP_A5);
    chk("recover_latency", lat, LAT);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
